// File: rtl/svm_rom_seq_pkg.sv
// svm_rom_seq_pkg: shared state encoding, FIFO entry layout and default sizes for the ROM sequencer
package svm_rom_seq_pkg;
  localparam int ROM_DEPTH_DEF       = 1024;
  localparam int ROM_TOTAL_WIDTH_DEF = 2048;
  localparam int FIFO_DEPTH_DEF      = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_t;
  typedef struct packed {
    logic                           last;
    logic [ROM_TOTAL_WIDTH_DEF-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/svm_seq_fifo.sv
// svm_seq_fifo: synchronous FIFO of entries of type T; rdata reads as zero while empty
module svm_seq_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q;
  logic            pop_ok;
  assign pop_ok = pop && !empty;
  assign count  = count_q;
  assign empty  = count_q == '0;
  assign full   = count_q == CW'(DEPTH);
  assign rdata  = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop_ok) rd_q <= (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/svm_rom_sequencer.sv
// svm_rom_sequencer: streams consecutive ROM rows through a credit-limited FIFO to the systolic array.
// Define SVM_ROM_SEQ_PERF_EN to add the stall_cycles backpressure counter.
module svm_rom_sequencer
  import svm_rom_seq_pkg::*;
#(
  parameter int ROM_DEPTH       = ROM_DEPTH_DEF,
  parameter int LOG_ROM_DEPTH   = $clog2(ROM_DEPTH),
  parameter int ROM_TOTAL_WIDTH = ROM_TOTAL_WIDTH_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [LOG_ROM_DEPTH-1:0]   start_addr,
  input  logic [LOG_ROM_DEPTH:0]     start_len,
  output logic [LOG_ROM_DEPTH-1:0]   rom_addr,
  input  logic [ROM_TOTAL_WIDTH-1:0] rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ROM_TOTAL_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
`ifdef SVM_ROM_SEQ_PERF_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  typedef struct packed {
    logic                       last;
    logic [ROM_TOTAL_WIDTH-1:0] data;
  } entry_t;
  seq_state_t               state_q, state_d;
  logic [LOG_ROM_DEPTH-1:0] row_q, row_d, addr_q;
  logic [LOG_ROM_DEPTH:0]   rem_q, rem_d;
  logic                     inflight_q, last_q, zero_done_q;
  logic                     accept, issue, pop, empty, full;
  logic [CW-1:0]            count;
  entry_t                   head;
  assign start_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign accept      = start_valid && start_ready;
  // A row read is a credit until it lands in the FIFO, so the FIFO can never overflow.
  assign issue = state_q == ISSUE && rem_q != '0 && !full &&
                 (({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH));
  assign rom_addr  = issue ? row_q : addr_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_last  = head.last;
  assign done      = zero_done_q || (state_q == DRAIN && empty && !inflight_q);
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (accept) begin
        row_d   = start_addr;
        rem_d   = start_len;
        state_d = (start_len == '0) ? IDLE : ISSUE;
      end
      ISSUE: begin
        row_d   = issue ? ((row_q == LOG_ROM_DEPTH'(ROM_DEPTH-1)) ? '0 : row_q + 1'b1) : row_q;
        rem_d   = issue ? rem_q - 1'b1 : rem_q;
        state_d = (rem_q == '0) ? DRAIN : ISSUE;
      end
      DRAIN:   state_d = (empty && !inflight_q) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      last_q      <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rem_q       <= rem_d;
      inflight_q  <= issue;
      last_q      <= issue && rem_q == (LOG_ROM_DEPTH+1)'(1);
      zero_done_q <= accept && start_len == '0;
      if (issue) addr_q <= row_q;
    end
  end
  svm_seq_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .wdata ('{last: last_q, data: rom_data}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
`ifdef SVM_ROM_SEQ_PERF_EN
  logic [31:0] stall_q;
  assign stall_cycles = stall_q;
  always_ff @(posedge clk)
    if (rst || accept) stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
`endif
endmodule

// File: tb/tb_svm_rom_sequencer.sv
// tb_svm_rom_sequencer: random-backpressure bench comparing streamed rows against a queue model of each job
module tb_svm_rom_sequencer;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [9:0]    start_addr = '0;
  logic [10:0]   start_len = '0;
  logic [9:0]    rom_addr;
  logic [2047:0] rom_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2047:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef SVM_ROM_SEQ_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  svm_rom_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_addr  (start_addr),
    .start_len   (start_len),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
`ifdef SVM_ROM_SEQ_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [2047:0] got, input logic [2047:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [2047:0] row_pat(input int a);
    logic [2047:0] r;
    logic [31:0]   w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'hC0FFEE00;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = w + 32'(i);
    return r;
  endfunction

  // ROM bank model: one-cycle read latency on the address seen during the cycle.
  logic [9:0] addr_s = '0;
  always @(negedge clk) addr_s = rom_addr;
  always @(posedge clk) rom_data <= row_pat(int'(addr_s));

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int            q[$];
  bit            mon_en = 1'b0, strict = 1'b0, prev_stall = 1'b0;
  int            j_addr, j_len, c0, rel, done_seen, done_rel, n_acc, stalls;
  logic [2047:0] prev_data;
  logic          prev_last;

  always @(negedge clk) if (mon_en) begin
    rel = cyc - c0;
    if (strict && rel >= 1 && rel <= j_len) check("rom_addr", 2048'(rom_addr), 2048'((j_addr + rel - 1) % 1024));
    if (strict) check("out_valid_timing", 2048'(out_valid), 2048'(rel >= 3 && rel <= j_len + 2));
    if (j_len == 0) check("busy_zero_len", 2048'(busy), 2048'(0));
    if (prev_stall) begin
      check("stall_valid", 2048'(out_valid), 2048'(1));
      check("stall_data", out_data, prev_data);
      check("stall_last", 2048'(out_last), 2048'(prev_last));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("extra_row", 2048'(1), 2048'(0));
      else begin
        check("row_data", out_data, row_pat(q.pop_front()));
        check("row_last", 2048'(out_last), 2048'(q.size() == 0));
      end
      n_acc++;
    end
    if (done) begin
      done_seen++;
      done_rel = rel;
    end
    if (out_valid && !out_ready) stalls++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  end

  task automatic start_job(input int a, input int l, input bit str);
    q.delete();
    for (int i = 0; i < l; i++) q.push_back((a + i) % 1024);
    @(posedge clk) #1;
    check("start_ready_idle", 2048'(start_ready), 2048'(1));
    strict = str; j_addr = a; j_len = l; c0 = cyc;
    done_seen = 0; done_rel = -1; n_acc = 0; stalls = 0; prev_stall = 1'b0;
    mon_en = 1'b1;
    start_valid = 1'b1;
    start_addr  = 10'(a);
    start_len   = 11'(l);
    @(posedge clk) #1;
    start_valid = 1'b0;
    start_addr  = 10'($urandom);
    start_len   = 11'($urandom);
  endtask

  task automatic finish_job(input int mx);
    for (int k = 0; k < mx && done_seen == 0; k++) @(posedge clk);
    #1;
    check("start_ready_after_done", 2048'(start_ready), 2048'(1));
    check("busy_after_done", 2048'(busy), 2048'(0));
    @(negedge clk);
    mon_en = 1'b0;
    check("done_count", 2048'(done_seen), 2048'(1));
    check("rows_accepted", 2048'(n_acc), 2048'(j_len));
    check("rows_left", 2048'(q.size()), 2048'(0));
    if (strict) check("done_cycle", 2048'(done_rel), 2048'(j_len == 0 ? 1 : j_len + 3));
`ifdef SVM_ROM_SEQ_PERF_EN
    check("stall_cycles", 2048'(stall_cycles), 2048'(stalls));
`endif
  endtask

  task automatic run_job(input int a, input int l, input bit rr);
    rnd_ready = rr;
    start_job(a, l, !rr);
    finish_job(rr ? 20 * l + 50 : l + 20);
    rnd_ready = 1'b0;
  endtask

  initial begin
    void'($urandom(42));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", 2048'(start_ready), 2048'(1));
    check("rst_busy", 2048'(busy), 2048'(0));
    check("rst_out_valid", 2048'(out_valid), 2048'(0));
    check("rst_out_last", 2048'(out_last), 2048'(0));
    check("rst_done", 2048'(done), 2048'(0));
    check("rst_rom_addr", 2048'(rom_addr), 2048'(0));
    check("rst_out_data", out_data, 2048'(0));
    @(posedge clk) #1 rst = 1'b0;

    run_job(0, 4, 1'b0);
    run_job(1022, 4, 1'b0);
    run_job(int'($urandom_range(0, 1023)), 16, 1'b1);
    run_job(7, 0, 1'b0);
    run_job(512, 1024, 1'b0);
    run_job(1023, 1, 1'b0);
    for (int i = 0; i < 4; i++) run_job(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1'b1);

    start_job(100, 20, 1'b1);
    for (int k = 0; k < 100 && n_acc < 5; k++) @(posedge clk);
    check("rows_before_reset", 2048'(n_acc), 2048'(5));
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_out_valid", 2048'(out_valid), 2048'(0));
    check("abort_busy", 2048'(busy), 2048'(0));
    check("abort_start_ready", 2048'(start_ready), 2048'(1));
    check("abort_done", 2048'(done), 2048'(0));
    @(posedge clk) #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_done_after_abort", 2048'(done), 2048'(0));
    end
    run_job(300, 10, 1'b0);
    run_job(1020, 12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
